// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional even parity,
// stop bit. The word is captured on a valid/ready handshake; all outputs are registered.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par;

    logic accept;
    logic bit_end;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign accept  = (state == IDLE) && valid && ready;
    assign bit_end = (state != IDLE) && (baud_cnt == BAUD_LAST);

    // Control path: state, counters and the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            ready    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                // ready rises one edge after reset release, so the first accept comes a cycle later
                ready <= 1'b1;
                if (accept) begin
                    state    <= START;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b0;
                    busy     <= 1'b1;
                    ready    <= 1'b0;
                end
            end else if (!bit_end) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                    end
                    DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= par;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Data path: shreg[0] always holds the next data bit to drive onto tx.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= data;
            par   <= even_parity(data);
        end else if (bit_end && ((state == START) || ((state == DATA) && (bit_cnt != BIT_LAST)))) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three parameterisations driven in turn, checked per cycle
// against a frame model built from the word with plain bit arithmetic.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    int         sel;

    int tests = 0;
    int fails = 0;

    logic v0, v1, v2;
    logic rdy0, rdy1, rdy2;
    logic tx0, tx1, tx2;
    logic bsy0, bsy1, bsy2;
    logic dn0, dn1, dn2;
    logic ready_o, tx_o, busy_o, done_o;

    assign v0 = valid && (sel == 0);
    assign v1 = valid && (sel == 1);
    assign v2 = valid && (sel == 2);

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u0 (
        .clk(clk), .rst(rst), .valid(v0), .data(data),
        .ready(rdy0), .tx(tx0), .busy(bsy0), .done(dn0));

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u1 (
        .clk(clk), .rst(rst), .valid(v1), .data(data),
        .ready(rdy1), .tx(tx1), .busy(bsy1), .done(dn1));

    serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(1)) u2 (
        .clk(clk), .rst(rst), .valid(v2), .data(data[3:0]),
        .ready(rdy2), .tx(tx2), .busy(bsy2), .done(dn2));

    always_comb begin
        ready_o = rdy0; tx_o = tx0; busy_o = bsy0; done_o = dn0;
        case (sel)
            1: begin ready_o = rdy1; tx_o = tx1; busy_o = bsy1; done_o = dn1; end
            2: begin ready_o = rdy2; tx_o = tx2; busy_o = bsy2; done_o = dn2; end
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (dut %0d, t=%0t): observed %b, expected %b", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_ready);
        chk({tag, "_tx"}, tx_o, 1'b1);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_ready"}, ready_o, exp_ready);
        chk({tag, "_done"}, done_o, 1'b0);
    endtask

    // Send one word on the selected DUT and check every cycle of the frame.
    task automatic send(input logic [7:0] d, input bit hold, input bit change);
        int dw, cpb, pen, ones, len;
        bit exp_bits[$];
        case (sel)
            1:       begin dw = 8; cpb = 4; pen = 0; end
            2:       begin dw = 4; cpb = 1; pen = 1; end
            default: begin dw = 8; cpb = 4; pen = 1; end
        endcase
        ones = 0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen != 0) exp_bits.push_back((ones % 2) == 1);
        exp_bits.push_back(1'b1);
        len = exp_bits.size() * cpb;

        chk("ready_before_accept", ready_o, 1'b1);
        data  = d;
        valid = 1'b1;
        step();
        if (!hold) valid = 1'b0;
        for (int j = 0; j < len; j++) begin
            chk($sformatf("tx_cyc%0d", j), tx_o, exp_bits[j / cpb]);
            chk("busy_frame", busy_o, 1'b1);
            chk("ready_frame", ready_o, 1'b0);
            chk("done_frame", done_o, 1'b0);
            if (change && j == 3 * cpb) data = 8'hFF;
            step();
        end
        chk("done_pulse", done_o, 1'b1);
        chk("tx_end", tx_o, 1'b1);
        chk("busy_end", busy_o, 1'b0);
        chk("ready_end", ready_o, 1'b1);
        if (!hold) begin
            step();
            chk_idle("after_done", 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        sel   = 0;
        rst   = 1'b0;
        valid = 1'b1;
        data  = 8'hA5;

        // Reset held with valid asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("reset", 1'b0);
        end
        rst = 1'b1;
        step();
        chk_idle("release", 1'b1);
        chk("release_ready_u1", rdy1, 1'b1);
        chk("release_ready_u2", rdy2, 1'b1);
        valid = 1'b0;
        step();
        chk_idle("no_frame", 1'b1);

        // Directed frames on default configuration
        send(8'hA5, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0);

        // Back-to-back with valid held, and data disturbed mid-frame
        send(8'h3C, 1'b1, 1'b1);
        send(8'hC3, 1'b0, 1'b0);

        // Reset during a frame
        data  = 8'hA5;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int j = 0; j < 19; j++) step();
        chk("pre_abort_busy", busy_o, 1'b1);
        rst = 1'b0;
        step();
        chk_idle("abort", 1'b0);
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk_idle("post_abort", 1'b1);
        end
        send(8'h5A, 1'b0, 1'b0);

        // No parity configuration
        sel = 1;
        step();
        send(8'h01, 1'b0, 1'b0);

        // One clock per bit, 4-bit words
        sel = 2;
        step();
        send(8'h0B, 1'b0, 1'b0);

        // Randomised words on every configuration
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < 3; s++) begin
                sel = s;
                step();
                if (s == 2) send(8'($urandom_range(0, 15)), 1'b0, 1'b0);
                else        send(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
